// File: rtl/keypad_if.sv
// Keypad scanner pin and result bundle: matrix row/column lines plus decoded key and entry outputs.
// Ports: key_col (in, active-low, async), key_row (out, active-low), key_code/key_valid/key_held,
//        entry_value/value_out/value_strobe. No handshake; outputs are pulses and levels.
interface keypad_if;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [13:0] entry_value;
    logic [13:0] value_out;
    logic        value_strobe;

    // master = the scanner; slave = keypad / consumer side
    modport master (
        input  key_col,
        output key_row, key_code, key_valid, key_held,
        output entry_value, value_out, value_strobe
    );

    modport slave (
        output key_col,
        input  key_row, key_code, key_valid, key_held,
        input  entry_value, value_out, value_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, ghost-rejecting frame classify, press/release debounce, decimal entry.
// Latency: press accepted DEBOUNCE_FRAMES frames after first detection + 1 clock; entry_value 1 clock after key_valid.
// Backpressure: none; key_valid and value_strobe are single-clock pulses that must be consumed when seen.
// Ports: clk, rst (sync, active-high); kp.master carries key_col in, key_row/key_code/key_valid/key_held,
//        entry_value (live 0..9999), value_out (last committed) and value_strobe out.
module keypad_scanner #(
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] CODE_STAR = 4'd12;
    localparam logic [3:0] CODE_HASH = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DEB,
        ST_HELD,
        ST_REL_DEB
    } state_t;

    // Returns {is_digit, digit} for a key code; letters, '*' and '#' return is_digit=0.
    function automatic logic [4:0] digit_of(input logic [3:0] code);
        case (code)
            4'd0:    digit_of = {1'b1, 4'd1};
            4'd1:    digit_of = {1'b1, 4'd2};
            4'd2:    digit_of = {1'b1, 4'd3};
            4'd4:    digit_of = {1'b1, 4'd4};
            4'd5:    digit_of = {1'b1, 4'd5};
            4'd6:    digit_of = {1'b1, 4'd6};
            4'd8:    digit_of = {1'b1, 4'd7};
            4'd9:    digit_of = {1'b1, 4'd8};
            4'd10:   digit_of = {1'b1, 4'd9};
            4'd13:   digit_of = {1'b1, 4'd0};
            default: digit_of = 5'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]        col_s1_q, col_s1_d;
    logic [3:0]        col_s2_q, col_s2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [3:0]        key_row_q, key_row_d;
    logic [15:0]       map_q, map_d;
    state_t            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
    logic [13:0]       entry_q, entry_d;
    logic [13:0]       value_out_q, value_out_d;
    logic              value_strobe_q, value_strobe_d;

    // Combinational helpers
    logic [15:0] frame_map;
    logic [4:0]  hit_cnt;
    logic [3:0]  hit_code;
    logic        frame_key;
    logic        frame_done;
    logic        accept;
    logic [4:0]  dig;
    logic [17:0] prod;

    always_comb begin
        col_s1_d       = kp.key_col;
        col_s2_d       = col_s1_q;
        slot_d         = slot_q;
        row_idx_d      = row_idx_q;
        key_row_d      = key_row_q;
        map_d          = map_q;
        state_d        = state_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        key_code_d     = key_code_q;
        key_valid_d    = 1'b0;
        key_held_d     = key_held_q;
        entry_d        = entry_q;
        value_out_d    = value_out_q;
        value_strobe_d = 1'b0;
        frame_done     = 1'b0;
        accept         = 1'b0;
        dig            = 5'd0;
        prod           = 18'd0;

        // Pressed map including the row being sampled this clock (columns are active-low).
        frame_map = map_q;
        frame_map[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;

        hit_cnt  = 5'd0;
        hit_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
        // Multiple keys are treated as no key: the matrix cannot resolve them reliably.
        frame_key = (hit_cnt == 5'd1);

        // Row scan: sample at the end of each slot so the synchronizer has settled on the new row.
        if (slot_q == SLOT_LAST) begin
            slot_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
            key_row_d = {key_row_q[2:0], key_row_q[3]};
            map_d     = frame_map;
            if (row_idx_q == 2'd3) begin
                map_d      = '0;
                frame_done = 1'b1;
            end
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end

        // Debounce, stepped once per completed frame.
        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_key) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_PRESS_DEB;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (frame_key && (hit_code == cand_q)) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if ((cnt_q + CNT_ONE) == DEB_LAST) begin
                            accept = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (!frame_key) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end else begin
                            state_d = ST_REL_DEB;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_REL_DEB: begin
                    if (frame_key) begin
                        // Key came back before release was confirmed: no new event.
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if ((cnt_q + CNT_ONE) == DEB_LAST) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (accept) begin
                state_d     = ST_HELD;
                cnt_d       = '0;
                key_code_d  = hit_code;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
            end
        end

        // Digit entry acts on the registered key event, so it lands one clock after key_valid.
        if (key_valid_q) begin
            dig = digit_of(key_code_q);
            if (dig[4]) begin
                // Wide multiply then reduce: overflow drops the leading digit.
                prod    = 18'(entry_q) * 18'd10 + 18'(dig[3:0]);
                entry_d = 14'(prod % 18'd10000);
            end else if (key_code_q == CODE_STAR) begin
                entry_d = '0;
            end else if (key_code_q == CODE_HASH) begin
                value_out_d    = entry_q;
                value_strobe_d = 1'b1;
                entry_d        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q       <= 4'b1111;
            col_s2_q       <= 4'b1111;
            slot_q         <= '0;
            row_idx_q      <= 2'd0;
            key_row_q      <= 4'b1110;
            map_q          <= '0;
            state_q        <= ST_IDLE;
            cand_q         <= 4'd0;
            cnt_q          <= '0;
            key_code_q     <= 4'd0;
            key_valid_q    <= 1'b0;
            key_held_q     <= 1'b0;
            entry_q        <= '0;
            value_out_q    <= '0;
            value_strobe_q <= 1'b0;
        end else begin
            col_s1_q       <= col_s1_d;
            col_s2_q       <= col_s2_d;
            slot_q         <= slot_d;
            row_idx_q      <= row_idx_d;
            key_row_q      <= key_row_d;
            map_q          <= map_d;
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            key_code_q     <= key_code_d;
            key_valid_q    <= key_valid_d;
            key_held_q     <= key_held_d;
            entry_q        <= entry_d;
            value_out_q    <= value_out_d;
            value_strobe_q <= value_strobe_d;
        end
    end

    assign kp.key_row      = key_row_q;
    assign kp.key_code     = key_code_q;
    assign kp.key_valid    = key_valid_q;
    assign kp.key_held     = key_held_q;
    assign kp.entry_value  = entry_q;
    assign kp.value_out    = value_out_q;
    assign kp.value_strobe = value_strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: ideal 4x4 keypad model, frame-level reference model, directed + random scenarios.
// Keys change only on frame boundaries, so each frame sees one stable key set.
// Checks scan order, debounce events, ghost rejection, entry arithmetic and reset behaviour.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;
    logic [3:0]  col;

    int errors = 0;
    int checks = 0;

    keypad_if kp ();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    always #5 clk = ~clk;

    // Ideal passive keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kp.key_row[r]) col = col & ~keys[r*4 +: 4];
        end
    end
    assign kp.key_col = col;

    // ---------------- observation of one frame window ----------------
    int         obs_valid;
    int         obs_strobe;
    logic [3:0] obs_rows [FRAME];

    task automatic drive_frame(input logic [15:0] k);
        keys       = k;
        obs_valid  = 0;
        obs_strobe = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            @(negedge clk);
            obs_rows[i] = kp.key_row;
            if (kp.key_valid === 1'b1) obs_valid++;
            if (kp.value_strobe === 1'b1) obs_strobe++;
        end
    endtask

    // ---------------- frame-level reference model ----------------
    string legend = "123A456B789C*0#D";
    int m_pend_code, m_pend_len, m_rel_len, m_code, m_entry, m_vout;
    bit m_held, m_strobe_next;
    int e_valid, e_strobe, e_entry, e_vout;

    task automatic model_reset();
        m_pend_code = 0; m_pend_len = 0; m_rel_len = 0; m_code = 0;
        m_entry = 0; m_vout = 0; m_held = 0; m_strobe_next = 0;
    endtask

    function automatic int classify(input logic [15:0] k);
        int idx = -1;
        if ($countones(k) == 1)
            for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        return idx;
    endfunction

    task automatic apply_key(input int code);
        byte ch = legend[code];
        if (ch >= "0" && ch <= "9") m_entry = (m_entry * 10 + (int'(ch) - 48)) % 10000;
        else if (ch == "*") m_entry = 0;
        else if (ch == "#") begin m_vout = m_entry; m_entry = 0; m_strobe_next = 1; end
    endtask

    // Entry/value changes from an event show up in the following frame window.
    task automatic model_frame(input logic [15:0] k);
        int r = classify(k);
        e_entry = m_entry; e_vout = m_vout; e_strobe = m_strobe_next;
        m_strobe_next = 0; e_valid = 0;
        if (!m_held) begin
            if (r < 0) m_pend_len = 0;
            else if (m_pend_len > 0 && r != m_pend_code) m_pend_len = 0;
            else begin m_pend_code = r; m_pend_len++; end
            if (m_pend_len == DEB) begin
                m_held = 1; m_code = r; m_pend_len = 0; m_rel_len = 0; e_valid = 1;
                apply_key(r);
            end
        end else begin
            if (r < 0) begin
                m_rel_len++;
                if (m_rel_len == DEB) begin m_held = 0; m_rel_len = 0; end
            end else m_rel_len = 0;
        end
    endtask

    task automatic step(input logic [15:0] k);
        drive_frame(k);
        model_frame(k);
    endtask

    task automatic press_key(input int code, output int pulses, output int strobes);
        pulses = 0; strobes = 0;
        for (int f = 0; f < 2 * DEB; f++) begin
            step((f < DEB) ? (16'd1 << code) : 16'd0);
            pulses += obs_valid; strobes += obs_strobe;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (kp.key_row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", kp.key_row); end
        checks++; if (kp.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", kp.key_code); end
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", kp.key_valid); end
        checks++; if (kp.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", kp.key_held); end
        checks++; if (kp.entry_value !== 14'd0) begin errors++; $display("FAIL reset_entry: got %0d want 0", kp.entry_value); end
        checks++; if (kp.value_out !== 14'd0) begin errors++; $display("FAIL reset_vout: got %0d want 0", kp.value_out); end
        checks++; if (kp.value_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", kp.value_strobe); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] want;
        for (int f = 0; f < 3; f++) begin
            step(16'h0);
            for (int i = 0; i < FRAME; i++) begin
                want = 4'b0001 << (((i + 1) / SCAN_DIV) % 4);
                want = ~want;
                checks++;
                if (obs_rows[i] !== want) begin
                    errors++; $display("FAIL scan_row f%0d s%0d: got %b want %b", f, i, obs_rows[i], want);
                end
            end
            checks++; if (obs_valid !== 0) begin errors++; $display("FAIL idle_valid: got %0d want 0", obs_valid); end
            checks++; if (kp.key_held !== 1'b0 || kp.entry_value !== 14'd0 || kp.value_out !== 14'd0)
                begin errors++; $display("FAIL idle_outputs: held=%b entry=%0d vout=%0d want 0", kp.key_held, kp.entry_value, kp.value_out); end
        end
    endtask

    task automatic test_hold_5();
        int total = 0;
        for (int f = 0; f < DEB + 20; f++) begin
            step(16'd1 << 5);
            total += obs_valid;
            checks++; if (obs_valid !== e_valid) begin errors++; $display("FAIL hold5_model f%0d: got %0d want %0d", f, obs_valid, e_valid); end
            if (f == DEB - 1) begin
                checks++; if (obs_valid !== 1 || kp.key_code !== 4'd5)
                    begin errors++; $display("FAIL hold5_accept: pulses=%0d code=%0d want 1/5", obs_valid, kp.key_code); end
            end
        end
        checks++; if (total !== 1) begin errors++; $display("FAIL hold5_single: got %0d pulses want 1", total); end
        checks++; if (kp.key_held !== 1'b1) begin errors++; $display("FAIL hold5_held: got %b want 1", kp.key_held); end
        for (int f = 0; f < DEB; f++) begin
            step(16'h0);
            checks++;
            if (kp.key_held !== ((f < DEB - 1) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL hold5_release f%0d: held=%b", f, kp.key_held); end
        end
    endtask

    task automatic test_chatter();
        logic [15:0] seq [8];
        int          want [8];
        seq  = '{16'h20, 16'h0, 16'h20, 16'h20, 16'h20, 16'h0, 16'h0, 16'h0};
        want = '{0, 0, 0, 0, 1, 0, 0, 0};
        for (int f = 0; f < 8; f++) begin
            step(seq[f]);
            checks++;
            if (obs_valid !== want[f] || obs_valid !== e_valid)
                begin errors++; $display("FAIL chatter f%0d: got %0d want %0d", f, obs_valid, want[f]); end
        end
    endtask

    task automatic test_entry();
        int codes [5];
        int vals  [5];
        int p, s;
        codes = '{0, 1, 2, 4, 5};
        vals  = '{1, 12, 123, 1234, 2345};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            press_key(codes[n], p, s);
            checks++; if (p !== 1) begin errors++; $display("FAIL entry_pulse %0d: got %0d want 1", n, p); end
            checks++; if (kp.entry_value !== 14'(vals[n]) || m_entry !== vals[n])
                begin errors++; $display("FAIL entry_value %0d: got %0d want %0d", n, kp.entry_value, vals[n]); end
        end
        press_key(14, p, s);
        checks++; if (kp.value_out !== 14'd2345) begin errors++; $display("FAIL commit_vout: got %0d want 2345", kp.value_out); end
        checks++; if (s !== 1) begin errors++; $display("FAIL commit_strobe: got %0d want 1", s); end
        checks++; if (kp.entry_value !== 14'd0) begin errors++; $display("FAIL commit_clear: got %0d want 0", kp.entry_value); end
    endtask

    task automatic test_star_letter();
        int p, s;
        press_key(8, p, s);
        checks++; if (kp.entry_value !== 14'd7) begin errors++; $display("FAIL seven: got %0d want 7", kp.entry_value); end
        press_key(12, p, s);
        checks++; if (kp.entry_value !== 14'd0 || kp.value_out !== 14'd2345 || s !== 0)
            begin errors++; $display("FAIL star: entry=%0d vout=%0d strobes=%0d want 0/2345/0", kp.entry_value, kp.value_out, s); end
        press_key(3, p, s);
        checks++; if (p !== 1 || kp.key_code !== 4'd3 || kp.entry_value !== 14'd0)
            begin errors++; $display("FAIL letter_a: pulses=%0d code=%0d entry=%0d want 1/3/0", p, kp.key_code, kp.entry_value); end
    endtask

    task automatic test_ghost();
        int total = 0;
        for (int f = 0; f < DEB + 3; f++) begin step(16'h0003); total += obs_valid; end
        step(16'h0);
        total += obs_valid;
        checks++; if (total !== 0 || kp.key_held !== 1'b0)
            begin errors++; $display("FAIL ghost: pulses=%0d held=%b want 0/0", total, kp.key_held); end
    endtask

    task automatic test_reset_held();
        int total = 0;
        for (int f = 0; f < DEB + 1; f++) begin step(16'd1 << 10); total += obs_valid; end
        checks++; if (total !== 1 || kp.key_held !== 1'b1 || kp.entry_value !== 14'd9)
            begin errors++; $display("FAIL nine_pre: pulses=%0d held=%b entry=%0d want 1/1/9", total, kp.key_held, kp.entry_value); end
        repeat (7) @(negedge clk);
        do_reset();
        checks++; if (kp.key_held !== 1'b0 || kp.key_code !== 4'd0 || kp.entry_value !== 14'd0 || kp.key_row !== 4'b1110)
            begin errors++; $display("FAIL midreset: held=%b code=%0d entry=%0d row=%b", kp.key_held, kp.key_code, kp.entry_value, kp.key_row); end
        total = 0;
        for (int f = 0; f < DEB + 2; f++) begin step(16'd1 << 10); total += obs_valid; end
        checks++; if (total !== 1 || kp.key_code !== 4'd10)
            begin errors++; $display("FAIL nine_redeb: pulses=%0d code=%0d want 1/10", total, kp.key_code); end
        for (int f = 0; f < DEB; f++) step(16'h0);
    endtask

    task automatic test_random();
        logic [15:0] k = 16'h0;
        int a, b;
        do_reset();
        for (int f = 0; f < 90; f++) begin
            if ($urandom_range(0, 99) >= 65) begin
                case ($urandom_range(0, 2))
                    0: k = 16'h0;
                    1: k = 16'd1 << $urandom_range(0, 15);
                    default: begin
                        a = $urandom_range(0, 15);
                        b = (a + 1 + $urandom_range(0, 14)) % 16;
                        k = (16'd1 << a) | (16'd1 << b);
                    end
                endcase
            end
            step(k);
            checks++; if (obs_valid !== e_valid) begin errors++; $display("FAIL rnd_valid f%0d: got %0d want %0d", f, obs_valid, e_valid); end
            checks++; if (obs_strobe !== e_strobe) begin errors++; $display("FAIL rnd_strobe f%0d: got %0d want %0d", f, obs_strobe, e_strobe); end
            checks++; if (kp.key_code !== 4'(m_code)) begin errors++; $display("FAIL rnd_code f%0d: got %0d want %0d", f, kp.key_code, m_code); end
            checks++; if (kp.key_held !== m_held) begin errors++; $display("FAIL rnd_held f%0d: got %b want %b", f, kp.key_held, m_held); end
            checks++; if (kp.entry_value !== 14'(e_entry)) begin errors++; $display("FAIL rnd_entry f%0d: got %0d want %0d", f, kp.entry_value, e_entry); end
            checks++; if (kp.value_out !== 14'(e_vout)) begin errors++; $display("FAIL rnd_vout f%0d: got %0d want %0d", f, kp.value_out, e_vout); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_hold_5();
        test_chatter();
        test_entry();
        test_star_letter();
        test_ghost();
        test_reset_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 4-digit FND display path.
- Scans a 4x4 matrix keypad by driving one row at a time and sampling the columns, the same time-multiplexing scheme the display uses in the opposite direction.
- Debounces key presses and emits single-cycle key events.
- Assembles decimal digit entry into a 0..9999 value, sized to match the display's count input.

Parameters:
- SCAN_DIV, 100_000: clocks per row slot (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-frame results required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_col  in  4  column inputs; active-low, externally pulled up; asynchronous.
- key_row  out  4  row drive; active-low, exactly one bit low at any time.
- key_code  out  4  code of the last accepted key, = row*4 + col.
- key_valid  out  1  one-clock pulse on an accepted press.
- key_held  out  1  high while the accepted key is held (HELD or REL_DEB state).
- entry_value  out  14  live digit-entry register, 0..9999; feeds the display.
- value_out  out  14  last committed value.
- value_strobe  out  1  one-clock pulse on commit.

Behaviour:
- Reset values:
  - key_row=4'b1110.
  - key_code=0, key_valid=0, key_held=0.
  - entry_value=0, value_out=0, value_strobe=0.
  - Slot counter=0, frame accumulator=0, synchronizer=4'b1111, FSM=IDLE, debounce counter=0.
- Column synchronizer: 2-FF on key_col, reset to 1s.
- Row scan:
  - Slot counter counts 0..SCAN_DIV-1.
  - At terminal count, sample the synchronized columns for the current row, then rotate key_row low bit: row0→1→2→3→0.
  - The sample is taken at the end of the slot, which gives settling time for the synchronizer.
- Frame evaluation: after the row3 sample, the 16-bit pressed map is classified.
  - Zero bits set → NONE.
  - Exactly one bit set → KEY(code).
  - Two or more bits set → NONE (ghosting rejected).
  - The map then clears for the next frame.
- Debounce FSM: evaluated once per frame; cnt = debounce counter.
  - IDLE:
    - KEY(c) → PRESS_DEB with cand=c, cnt=1.
    - If DEBOUNCE_FRAMES=1, accept immediately.
  - PRESS_DEB:
    - Same KEY(cand) → cnt+1; when cnt reaches DEBOUNCE_FRAMES → HELD.
    - Any other result → IDLE.
  - HELD:
    - Entry into HELD: key_code←cand, key_valid=1 for exactly one clock (the clock after frame evaluation), key_held=1.
    - NONE → REL_DEB with cnt=1.
    - Different KEY or the same key → stay in HELD; no repeat, no new event.
  - REL_DEB:
    - NONE → cnt+1; at DEBOUNCE_FRAMES → IDLE and key_held=0.
    - Any KEY → back to HELD with no event.
- Press latency: DEBOUNCE_FRAMES frames after the first frame that detects the key, plus 1 clock.
- Key map by code:
  - Codes 0,1,2 = '1','2','3'; 3 = 'A'.
  - Codes 4,5,6 = '4','5','6'; 7 = 'B'.
  - Codes 8,9,10 = '7','8','9'; 11 = 'C'.
  - Code 12 = '*'; 13 = '0'; 14 = '#'; 15 = 'D'.
- Entry: applied in the same clock as key_valid; entry_value is updated one clock later.
  - Digit d: entry_value ← (entry_value*10 + d) mod 10000. Compute at ≥18-bit width, then reduce; overflow drops the most significant digit.
  - '*': entry_value ← 0.
  - '#': value_out ← entry_value, value_strobe pulses 1 clock, entry_value ← 0.
  - A–D: no effect on entry; key_valid still pulses.
- Only one event is possible per frame, so entry operations never collide.
- Reset mid-frame or mid-debounce: all state returns to reset values; a key still held after reset must re-debounce from IDLE and produces one new key_valid.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3):
- Reset, no keys → key_row cycles 1110,1101,1011,0111 every 4 clocks; key_valid is never asserted; all outputs stay 0.
- Hold '5' (row1, col1) stable → exactly one key_valid with key_code=5 after 3 frames (+1 clock); key_held=1; no second pulse during 20 held frames; key_held drops 3 frames after release.
- Press '5' with 1-frame chatter (press, release, press) → no event until 3 consecutive frames of the key; then a single pulse.
- Press '1','2','3','4','5' → entry_value goes 1, 12, 123, 1234, 2345; then '#' → value_out=2345, one value_strobe pulse, entry_value=0.
- Press '7' then '*' → entry_value=0 and value_out unchanged; press 'A' → key_valid with key_code=3 and entry_value unchanged.
- Press '1' and '2' simultaneously → no event (ghost rejection); assert rst while holding '9' in HELD → outputs return to reset values; '9' re-debounces and pulses key_valid with key_code=10 once.
